// File: rtl/hub_rx.sv
// hub_rx: serial receive stage. Requests a frame with SBF, deserialises SD into a
// DEPTH-byte buffer until CD rises. Optional WAIT_START timeout: define HUB_RX_TIMEOUT_EN.
module hub_rx #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          TRD,
    input  logic          SD,
    input  logic          CD,
    output logic          SBF,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [5:0]    byte_count,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overflow,
    output logic          err_truncated,
    output logic          err_timeout,
    output logic [2:0]    state_out
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARMED      = 3'd1,
        S_REQ        = 3'd2,
        S_WAIT_START = 3'd3,
        S_DATA       = 3'd4,
        S_GAP        = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    state_t      state_q, state_d;
    logic [5:0]  byte_count_q, byte_count_d;
    logic        err_overflow_q, err_overflow_d;
    logic        err_truncated_q, err_truncated_d;
    logic        frame_done_q, frame_done_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_data_q;
    logic [7:0]  mem_q [DEPTH];

    logic start_bit;
    logic last_bit;
    logic timeout_hit;
    logic arm_accept;

    assign start_bit  = !CD && !SD;
    assign last_bit   = (bit_idx_q == 3'd7);
    assign arm_accept = (state_d == S_ARMED) && (state_q != S_ARMED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (arm) state_d = S_ARMED;
            S_ARMED:      if (TRD) state_d = S_REQ;
            S_REQ:        state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (start_bit)        state_d = S_DATA;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_DATA: begin
                if (CD)            state_d = S_DONE;
                else if (last_bit) state_d = S_GAP;
            end
            S_GAP: begin
                if (CD)       state_d = S_DONE;
                else if (!SD) state_d = S_DATA;
            end
            S_DONE:       if (arm) state_d = S_ARMED;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        SBF       = (state_q == S_REQ);
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        state_out = state_q;
    end

    // Completed bytes go through a one-cycle write stage before reaching the buffer.
    always_comb begin
        byte_count_d    = byte_count_q;
        err_overflow_d  = err_overflow_q;
        err_truncated_d = err_truncated_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        frame_done_d    = (state_d == S_DONE) && (state_q != S_DONE);

        if (arm_accept) begin
            byte_count_d    = '0;
            err_overflow_d  = 1'b0;
            err_truncated_d = 1'b0;
        end

        if ((state_d == S_DATA) && (state_q != S_DATA)) begin
            bit_idx_d = 3'd0;
        end

        if (state_q == S_DATA) begin
            if (CD) begin
                err_truncated_d = 1'b1;
            end else begin
                shift_d   = {SD, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                if (last_bit) begin
                    wr_addr_d = byte_count_q[AW-1:0];
                    wr_data_d = {SD, shift_q[7:1]};
                    if ({1'b0, byte_count_q} < DEPTH_W) begin
                        wr_en_d = 1'b1;
                    end else begin
                        err_overflow_d = 1'b1;
                    end
                    if (byte_count_q != 6'd63) begin
                        byte_count_d = byte_count_q + 6'd1;
                    end
                end
            end
        end

        if ((state_q == S_WAIT_START) && (state_d == S_DONE)) begin
            byte_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q    <= '0;
            err_overflow_q  <= 1'b0;
            err_truncated_q <= 1'b0;
            frame_done_q    <= 1'b0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            byte_count_q    <= byte_count_d;
            err_overflow_q  <= err_overflow_d;
            err_truncated_q <= err_truncated_d;
            frame_done_q    <= frame_done_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
        end
    end

    // Buffer contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

`ifdef HUB_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_timeout_q, err_timeout_d;

    // Up to TIMEOUT start-bit samples are allowed after the SBF cycle.
    assign timeout_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d     = tmo_cnt_q;
        err_timeout_d = err_timeout_q;
        if (arm_accept) begin
            err_timeout_d = 1'b0;
        end
        if (state_q == S_REQ) begin
            tmo_cnt_d = '0;
        end else if ((state_q == S_WAIT_START) && !start_bit) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (timeout_hit) begin
                err_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    assign rd_data       = rd_data_q;
    assign byte_count    = byte_count_q;
    assign frame_done    = frame_done_q;
    assign err_overflow  = err_overflow_q;
    assign err_truncated = err_truncated_q;

endmodule

// File: tb/tb_hub_rx.sv
// Self-checking bench for hub_rx: random frames against a byte-level frame/buffer model.
module tb_hub_rx;

    logic       clk = 1'b0;
    logic       reset, arm, TRD, SD, CD;
    logic [4:0] rd_addr;
    logic       SBF, busy, frame_done, err_overflow, err_truncated, err_timeout;
    logic [7:0] rd_data;
    logic [5:0] byte_count;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;
    int sbf_total = 0;
    int fd_total = 0;

    logic [7:0] mem_m [32];
    logic [7:0] tx [64];

    always #5 clk = ~clk;

    hub_rx dut (
        .clk(clk), .reset(reset), .arm(arm), .TRD(TRD), .SD(SD), .CD(CD),
        .SBF(SBF), .rd_addr(rd_addr), .rd_data(rd_data), .byte_count(byte_count),
        .busy(busy), .frame_done(frame_done), .err_overflow(err_overflow),
        .err_truncated(err_truncated), .err_timeout(err_timeout), .state_out(state_out)
    );

    always @(negedge clk) begin
        if (SBF === 1'b1) sbf_total <= sbf_total + 1;
        if (frame_done === 1'b1) fd_total <= fd_total + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start bit followed by nbits data bits, LSB first.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        SD = 1'b0; CD = 1'b0;
        tick;
        for (int i = 0; i < nbits; i++) begin
            SD = b[i];
            tick;
        end
    endtask

    task automatic start_frame(output int sbf0, output int fd0);
        int k;
        sbf0 = sbf_total;
        fd0  = fd_total;
        CD = 1'b0; SD = 1'b1; arm = 1'b1;
        tick;
        arm = 1'b0;
        checks++;
        if (state_out !== 3'd1 || byte_count !== 6'd0 || {err_overflow, err_truncated, err_timeout} !== 3'b000)
            $display("FAIL arm_clear state=%0d count=%0d errs=%b expected state=1 count=0 errs=000",
                     state_out, byte_count, {err_overflow, err_truncated, err_timeout});
        TRD = 1'b1;
        k = 0;
        while (SBF !== 1'b1 && k < 10) begin
            tick;
            k++;
        end
        checks++;
        if (SBF !== 1'b1 || k !== 1) begin
            errors++;
            $display("FAIL sbf_latency SBF=%b after %0d cycles expected 1 after 1", SBF, k);
        end
        TRD = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b1 || state_out !== 3'd3) begin
            errors++;
            $display("FAIL wait_start busy=%b state=%0d expected busy=1 state=3", busy, state_out);
        end
    endtask

    task automatic finish_frame(input int nb, input bit trunc, input int sbf0, input int fd0);
        int exp_cnt;
        CD = 1'b1;
        tick;
        checks++;
        if (frame_done !== 1'b1 || state_out !== 3'd6) begin
            errors++;
            $display("FAIL frame_done_pulse fd=%b state=%0d expected fd=1 state=6", frame_done, state_out);
        end
        tick;
        exp_cnt = (nb > 63) ? 63 : nb;
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width fd=%b busy=%b expected 0 0", frame_done, busy);
        end
        checks++;
        if ((sbf_total - sbf0) !== 1 || (fd_total - fd0) !== 1) begin
            errors++;
            $display("FAIL pulse_counts sbf=%0d fd=%0d expected 1 1", sbf_total - sbf0, fd_total - fd0);
        end
        checks++;
        if (byte_count !== 6'(exp_cnt)) begin
            errors++;
            $display("FAIL byte_count got %0d expected %0d", byte_count, exp_cnt);
        end
        checks++;
        if (err_overflow !== (nb > 32) || err_truncated !== trunc || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_flags ovf=%b trunc=%b tmo=%b expected %b %b 0",
                     err_overflow, err_truncated, err_timeout, nb > 32, trunc);
        end
        for (int i = 0; i < nb && i < 32; i++) mem_m[i] = tx[i];
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            tick;
            checks++;
            if (rd_data !== mem_m[a]) begin
                errors++;
                $display("FAIL readback addr=%0d got %02h expected %02h", a, rd_data, mem_m[a]);
            end
        end
    endtask

    task automatic run_frame(input int n, input int cut, input int cut_bits);
        int sbf0, fd0, nb;
        start_frame(sbf0, fd0);
        repeat ($urandom_range(0, 4)) tick;
        nb = n;
        for (int j = 0; j < n; j++) begin
            if (j == cut) begin
                send_bits(tx[j], cut_bits);
                nb = j;
                break;
            end
            send_bits(tx[j], 8);
            SD = 1'b1;
            repeat ($urandom_range(0, 2)) tick;
        end
        finish_frame(nb, (cut >= 0 && cut < n), sbf0, fd0);
        $display("frame n=%0d cut=%0d stored=%0d", n, cut, nb);
    endtask

    task automatic test_reset;
        reset = 1'b1; arm = 1'b0; TRD = 1'b0; SD = 1'b1; CD = 1'b0; rd_addr = '0;
        tick;
        tick;
        checks++;
        if (state_out !== 3'd0 || SBF !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl state=%0d sbf=%b busy=%b fd=%b expected 0 0 0 0",
                     state_out, SBF, busy, frame_done);
        end
        checks++;
        if (byte_count !== 6'd0 || rd_data !== 8'd0 || {err_overflow, err_truncated, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_data count=%0d rd=%02h errs=%b expected 0 00 000",
                     byte_count, rd_data, {err_overflow, err_truncated, err_timeout});
        end
        reset = 1'b0;
        tick;
        $display("reset done state=%0d", state_out);
    endtask

    task automatic test_trd_unarmed;
        TRD = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if (SBF !== 1'b0 || state_out !== 3'd0) begin
                errors++;
                $display("FAIL trd_idle cycle=%0d sbf=%b state=%0d expected 0 0", i, SBF, state_out);
            end
        end
        arm = 1'b1;
        tick;
        arm = 1'b0;
        checks++;
        if (state_out !== 3'd1 || SBF !== 1'b0) begin
            errors++;
            $display("FAIL arm_trd_same state=%0d sbf=%b expected 1 0", state_out, SBF);
        end
        tick;
        checks++;
        if (SBF !== 1'b1 || state_out !== 3'd2) begin
            errors++;
            $display("FAIL sbf_after_arm sbf=%b state=%0d expected 1 2", SBF, state_out);
        end
        tick;
        checks++;
        if (SBF !== 1'b0 || state_out !== 3'd3) begin
            errors++;
            $display("FAIL sbf_one_cycle sbf=%b state=%0d expected 0 3", SBF, state_out);
        end
        TRD = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        $display("trd_unarmed done");
    endtask

    task automatic test_frame32;
        for (int i = 0; i < 32; i++) tx[i] = 8'(i);
        run_frame(32, -1, 0);
        rd_addr = 5'd5;
        tick;
        checks++;
        if (rd_data !== 8'h05) begin
            errors++;
            $display("FAIL addr5 got %02h expected 05", rd_data);
        end
    endtask

    task automatic test_truncate;
        for (int i = 0; i < 12; i++) tx[i] = 8'($urandom);
        run_frame(12, 10, 4);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 32; i++) tx[i] = 8'($urandom);
        tx[32] = 8'hAA;
        run_frame(33, -1, 0);
    endtask

    task automatic test_random_frames;
        int n, cut;
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
            cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_frame(n, cut, $urandom_range(0, 7));
        end
    endtask

    task automatic test_timeout;
        int sbf0, fd0, n;
        start_frame(sbf0, fd0);
        SD = 1'b1; CD = 1'b0;
`ifdef HUB_RX_TIMEOUT_EN
        n = 1;
        while (frame_done !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        checks++;
        if (frame_done !== 1'b1 || n < 64 || n > 66) begin
            errors++;
            $display("FAIL timeout_latency fd=%b cycles=%0d expected 1 within 64..66", frame_done, n);
        end
        checks++;
        if (err_timeout !== 1'b1 || byte_count !== 6'd0 || state_out !== 3'd6) begin
            errors++;
            $display("FAIL timeout_flags tmo=%b count=%0d state=%0d expected 1 0 6",
                     err_timeout, byte_count, state_out);
        end
`else
        n = 0;
        repeat (200) begin
            tick;
            n++;
        end
        checks++;
        if (state_out !== 3'd3 || err_timeout !== 1'b0 || (fd_total - fd0) !== 0) begin
            errors++;
            $display("FAIL no_timeout state=%0d tmo=%b fd=%0d expected 3 0 0",
                     state_out, err_timeout, fd_total - fd0);
        end
`endif
        reset = 1'b1;
        tick;
        reset = 1'b0;
        $display("timeout test cycles=%0d sbf=%0d", n, sbf_total - sbf0);
    endtask

    task automatic test_reset_mid;
        int sbf0, fd0;
        for (int i = 0; i < 5; i++) tx[i] = 8'($urandom);
        start_frame(sbf0, fd0);
        for (int j = 0; j < 4; j++) send_bits(tx[j], 8);
        send_bits(tx[4], 3);
        reset = 1'b1;
        tick;
        checks++;
        if (state_out !== 3'd0 || SBF !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            byte_count !== 6'd0 || rd_data !== 8'd0 ||
            {err_overflow, err_truncated, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid state=%0d busy=%b count=%0d rd=%02h expected all reset values",
                     state_out, busy, byte_count, rd_data);
        end
        reset = 1'b0;
        for (int j = 0; j < 4; j++) mem_m[j] = tx[j];
        tx[0] = 8'h5A;
        tx[1] = 8'hC3;
        run_frame(2, -1, 0);
    endtask

    initial begin
        test_reset;
        test_trd_unarmed;
        test_frame32;
        test_truncate;
        test_overflow;
        test_random_frames;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
